// File: rtl/jk_bank_driver.sv
// jk_bank_driver: steers a bank of JK flip-flops to a requested target word.
// Each attempt drives J/K for exactly one clock, waits one clock for the
// bank to settle, then compares q_fb against the target. A mismatch
// triggers a bounded number of re-drives before the attempt is abandoned.
module jk_bank_driver #(
  parameter int WIDTH       = 4,
  parameter int MAX_RETRY   = 3,
  parameter int TOGGLE_MODE = 0,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RW-1:0]    retries
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [RW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] j_q, j_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [RW-1:0]    retries_q, retries_d;

  // J input from the excitation table: only bits that must change get J=1
  // for a 0->1 move (or for any move in toggle mode).
  function automatic logic [WIDTH-1:0] exc_j(input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] chg;
    chg = q ^ t;
    if (TOGGLE_MODE != 0) return chg;
    return chg & t;
  endfunction

  // K input from the excitation table: 1->0 moves (or any move when toggling).
  function automatic logic [WIDTH-1:0] exc_k(input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] chg;
    chg = q ^ t;
    if (TOGGLE_MODE != 0) return chg;
    return chg & ~t;
  endfunction

  // Ready is gated by reset so no source can hand over a word mid-reset.
  assign tgt_ready = (state_q == IDLE) && rst;
  assign busy      = (state_q != IDLE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign retries   = retries_q;

  // Next-state logic; J/K default to zero so they are live only in DRIVE.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    j_d       = '0;
    k_d       = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    retries_d = retries_q;
    case (state_q)
      IDLE: begin
        if (tgt_valid && tgt_ready) begin
          tgt_d   = tgt_data;
          j_d     = exc_j(q_fb, tgt_data);
          k_d     = exc_k(q_fb, tgt_data);
          cnt_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        state_d = SETTLE;
      end
      SETTLE: begin
        if (q_fb == tgt_q) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          retries_d = cnt_q;
        end else if (cnt_q < RW'(MAX_RETRY)) begin
          cnt_d   = cnt_q + RW'(1);
          j_d     = exc_j(q_fb, tgt_q);
          k_d     = exc_k(q_fb, tgt_q);
          state_d = DRIVE;
        end else begin
          state_d   = IDLE;
          err_d     = 1'b1;
          retries_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      cnt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      done_q    <= done_d;
      err_q     <= err_d;
      retries_q <= retries_d;
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench for jk_bank_driver: two instances (set/reset and toggle encodings)
// share stimulus, each driving its own modelled JK flop bank.
module tb_jk_bank_driver;
  localparam int MAXR = 3;

  logic       clk, rst, tv;
  logic [3:0] td;
  logic       tr [2];
  logic       bz [2];
  logic       dn [2];
  logic       er [2];
  logic [3:0] jj [2];
  logic [3:0] kk [2];
  logic [3:0] qf [2];
  logic [1:0] rt [2];

  logic       load_en;
  logic [3:0] load_val, stuck_mask, skip_mask;
  logic       skip_used [2];

  int checks   = 0;
  int failures = 0;

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(MAXR), .TOGGLE_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .tgt_valid(tv), .tgt_data(td), .tgt_ready(tr[0]),
    .q_fb(qf[0]), .j(jj[0]), .k(kk[0]), .busy(bz[0]), .done(dn[0]),
    .err(er[0]), .retries(rt[0]));

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(MAXR), .TOGGLE_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .tgt_valid(tv), .tgt_data(td), .tgt_ready(tr[1]),
    .q_fb(qf[1]), .j(jj[1]), .k(kk[1]), .busy(bz[1]), .done(dn[1]),
    .err(er[1]), .retries(rt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Ideal JK flop behaviour for one clock.
  function automatic logic [3:0] jk_step(input logic [3:0] q, input logic [3:0] jv,
                                         input logic [3:0] kv);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) begin
      case ({jv[b], kv[b]})
        2'b00:   r[b] = q[b];
        2'b01:   r[b] = 1'b0;
        2'b10:   r[b] = 1'b1;
        default: r[b] = ~q[b];
      endcase
    end
    return r;
  endfunction

  // Flop bank: ideal flops, optional stuck-at-0 bits, optional one-time
  // ignored drive on selected bits, and a direct preload.
  always @(posedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (load_en) begin
        qf[n]        <= load_val & ~stuck_mask;
        skip_used[n] <= 1'b0;
      end else if (skip_mask != 4'b0 && !skip_used[n] &&
                   ((jj[n] | kk[n]) & skip_mask) != 4'b0) begin
        qf[n]        <= ((jk_step(qf[n], jj[n], kk[n]) & ~skip_mask) |
                         (qf[n] & skip_mask)) & ~stuck_mask;
        skip_used[n] <= 1'b1;
      end else begin
        qf[n] <= jk_step(qf[n], jj[n], kk[n]) & ~stuck_mask;
      end
    end
  end

  // Excitation table lookup, returns {J,K}.
  function automatic logic [7:0] exc(input logic [3:0] q, input logic [3:0] t, input bit tog);
    logic [3:0] jv, kv;
    for (int b = 0; b < 4; b++) begin
      case ({q[b], t[b]})
        2'b01:   begin jv[b] = 1'b1; kv[b] = tog; end
        2'b10:   begin jv[b] = tog;  kv[b] = 1'b1; end
        default: begin jv[b] = 1'b0; kv[b] = 1'b0; end
      endcase
    end
    return {jv, kv};
  endfunction

  // Transaction model: a busy transaction alternates drive (even elapsed
  // cycle) and settle (odd); each settle end decides done / retry / error.
  bit         m_busy [2];
  int         m_el   [2];
  int         m_att  [2];
  logic [3:0] m_tgt  [2];
  logic [3:0] m_jw   [2];
  logic [3:0] m_kw   [2];
  logic       m_done [2];
  logic       m_err  [2];
  logic [1:0] m_ret  [2];

  always @(posedge clk or negedge rst) begin
    for (int n = 0; n < 2; n++) begin
      if (!rst) begin
        m_busy[n] <= 1'b0; m_el[n] <= 0; m_att[n] <= 0; m_tgt[n] <= 4'b0;
        m_jw[n] <= 4'b0; m_kw[n] <= 4'b0; m_done[n] <= 1'b0; m_err[n] <= 1'b0;
        m_ret[n] <= 2'b0;
      end else begin
        m_done[n] <= 1'b0;
        m_err[n]  <= 1'b0;
        if (!m_busy[n]) begin
          if (tv) begin
            m_busy[n] <= 1'b1;
            m_el[n]   <= 0;
            m_att[n]  <= 0;
            m_tgt[n]  <= td;
            {m_jw[n], m_kw[n]} <= exc(qf[n], td, n == 1);
          end
        end else if (m_el[n] % 2 == 0) begin
          m_el[n] <= m_el[n] + 1;
        end else if (qf[n] == m_tgt[n]) begin
          m_busy[n] <= 1'b0;
          m_done[n] <= 1'b1;
          m_ret[n]  <= 2'(m_att[n]);
        end else if (m_att[n] < MAXR) begin
          m_att[n] <= m_att[n] + 1;
          m_el[n]  <= m_el[n] + 1;
          {m_jw[n], m_kw[n]} <= exc(qf[n], m_tgt[n], n == 1);
        end else begin
          m_busy[n] <= 1'b0;
          m_err[n]  <= 1'b1;
          m_ret[n]  <= 2'(m_att[n]);
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("ready%0d@%0t", n, $time), 32'(tr[n]), 32'(rst && !m_busy[n]));
      chk($sformatf("busy%0d@%0t", n, $time), 32'(bz[n]), 32'(m_busy[n]));
      chk($sformatf("done%0d@%0t", n, $time), 32'(dn[n]), 32'(m_done[n]));
      chk($sformatf("err%0d@%0t", n, $time), 32'(er[n]), 32'(m_err[n]));
      chk($sformatf("retries%0d@%0t", n, $time), 32'(rt[n]), 32'(m_ret[n]));
      chk($sformatf("j%0d@%0t", n, $time), 32'(jj[n]),
          32'((m_busy[n] && (m_el[n] % 2 == 0)) ? m_jw[n] : 4'b0000));
      chk($sformatf("k%0d@%0t", n, $time), 32'(kk[n]),
          32'((m_busy[n] && (m_el[n] % 2 == 0)) ? m_kw[n] : 4'b0000));
    end
  end

  logic [3:0] dj [2][8];
  logic [3:0] dk [2][8];
  int         ndrv, lat;
  logic       gotd, gote;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [3:0] v);
    load_en  = 1'b1;
    load_val = v;
    step();
    load_en  = 1'b0;
  endtask

  // Offer one target, record every drive phase, stop at done or err.
  task automatic xact(input string nm, input logic [3:0] t, input int budget);
    tv = 1'b1;
    td = t;
    step();
    tv = 1'b0;
    ndrv = 0; lat = -1; gotd = 1'b0; gote = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (dn[0] || dn[1] || er[0] || er[1]) begin
        lat = c; gotd = dn[0]; gote = er[0];
        break;
      end
      if (c % 2 == 0 && ndrv < 8) begin
        for (int n = 0; n < 2; n++) begin
          dj[n][ndrv] = jj[n];
          dk[n][ndrv] = kk[n];
        end
        ndrv++;
      end
      step();
    end
    chk({nm, "_finished"}, 32'(lat >= 0), 32'd1);
  endtask

  int lowcnt;
  bit seen;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; tv = 1'b1; td = 4'b1111;
    load_en = 1'b1; load_val = 4'b0000; stuck_mask = 4'b0; skip_mask = 4'b0;

    // Reset held with a target offered.
    repeat (3) @(posedge clk);
    #2;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("rst_ready%0d", n), 32'(tr[n]), 32'd0);
      chk($sformatf("rst_j%0d", n), 32'(jj[n]), 32'd0);
      chk($sformatf("rst_k%0d", n), 32'(kk[n]), 32'd0);
      chk($sformatf("rst_done%0d", n), 32'(dn[n]), 32'd0);
      chk($sformatf("rst_busy%0d", n), 32'(bz[n]), 32'd0);
    end
    rst = 1'b1; tv = 1'b0; load_en = 1'b0;
    step();
    for (int n = 0; n < 2; n++) chk($sformatf("post_rst_ready%0d", n), 32'(tr[n]), 32'd1);

    // Basic: 0101 -> 0011.
    load(4'b0101);
    xact("basic", 4'b0011, 12);
    chk("basic_lat", 32'(lat), 32'd2);
    chk("basic_done", 32'(gotd), 32'd1);
    chk("basic_j0", 32'(dj[0][0]), 32'b0010);
    chk("basic_k0", 32'(dk[0][0]), 32'b0100);
    chk("basic_j1", 32'(dj[1][0]), 32'b0110);
    chk("basic_k1", 32'(dk[1][0]), 32'b0110);
    chk("basic_q0", 32'(qf[0]), 32'b0011);
    chk("basic_q1", 32'(qf[1]), 32'b0011);
    chk("basic_ret0", 32'(rt[0]), 32'd0);

    // Toggle encoding: 1100 -> 0110.
    load(4'b1100);
    xact("toggle", 4'b0110, 12);
    chk("toggle_lat", 32'(lat), 32'd2);
    chk("toggle_done1", 32'(dn[1]), 32'd1);
    chk("toggle_j1", 32'(dj[1][0]), 32'b1010);
    chk("toggle_k1", 32'(dk[1][0]), 32'b1010);
    chk("toggle_j0", 32'(dj[0][0]), 32'b0010);
    chk("toggle_k0", 32'(dk[0][0]), 32'b1000);
    chk("toggle_q1", 32'(qf[1]), 32'b0110);

    // Bit0 stuck at 0: retries exhaust.
    stuck_mask = 4'b0001;
    load(4'b0000);
    xact("stuck", 4'b0001, 16);
    chk("stuck_lat", 32'(lat), 32'd8);
    chk("stuck_err", 32'(gote), 32'd1);
    chk("stuck_nodone", 32'(gotd), 32'd0);
    chk("stuck_ndrv", 32'(ndrv), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stuck_j0_%0d", i), 32'(dj[0][i]), 32'b0001);
      chk($sformatf("stuck_j1_%0d", i), 32'(dj[1][i]), 32'b0001);
    end
    chk("stuck_ret0", 32'(rt[0]), 32'd3);
    chk("stuck_ret1", 32'(rt[1]), 32'd3);
    stuck_mask = 4'b0000;

    // First drive on bit2 ignored: one retry then success.
    load(4'b0000);
    skip_mask = 4'b0100;
    xact("skip", 4'b0100, 16);
    chk("skip_lat", 32'(lat), 32'd4);
    chk("skip_done", 32'(gotd), 32'd1);
    chk("skip_ndrv", 32'(ndrv), 32'd2);
    chk("skip_j0_2nd", 32'(dj[0][1]), 32'b0100);
    chk("skip_ret0", 32'(rt[0]), 32'd1);
    skip_mask = 4'b0000;

    // Target equal to current state still takes two cycles with J=K=0.
    load(4'b1010);
    xact("same", 4'b1010, 12);
    chk("same_lat", 32'(lat), 32'd2);
    chk("same_done", 32'(gotd), 32'd1);
    chk("same_j", 32'(dj[0][0] | dj[1][0]), 32'd0);
    chk("same_k", 32'(dk[0][0] | dk[1][0]), 32'd0);

    // Reset during DRIVE aborts with no pulse.
    load(4'b0000);
    tv = 1'b1; td = 4'b1111;
    step();
    tv = 1'b0;
    chk("abort_drive_j0", 32'(jj[0]), 32'b1111);
    rst = 1'b0;
    #1;
    for (int n = 0; n < 2; n++) begin
      chk($sformatf("abort_j%0d", n), 32'(jj[n]), 32'd0);
      chk($sformatf("abort_k%0d", n), 32'(kk[n]), 32'd0);
      chk($sformatf("abort_busy%0d", n), 32'(bz[n]), 32'd0);
      chk($sformatf("abort_ready%0d", n), 32'(tr[n]), 32'd0);
    end
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("abort_quiet%0d", c), 32'(dn[0] | dn[1] | er[0] | er[1]), 32'd0);
    end

    // Back-to-back: second target accepted in the done cycle.
    load(4'b0000);
    tv = 1'b1; td = 4'b0011;
    step();
    td = 4'b0110;
    lowcnt = 0; seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (!bz[0]) lowcnt++;
      if (dn[0]) begin
        seen = 1'b1;
        chk("b2b_ready_in_done", 32'(tr[0]), 32'd1);
        break;
      end
      step();
    end
    chk("b2b_first_done", 32'(seen), 32'd1);
    chk("b2b_q_first", 32'(qf[0]), 32'b0011);
    step();
    tv = 1'b0;
    chk("b2b_busy_again", 32'(bz[0]), 32'd1);
    chk("b2b_gap", 32'(lowcnt), 32'd1);
    chk("b2b_j0", 32'(jj[0]), 32'b0100);
    chk("b2b_k0", 32'(kk[0]), 32'b0001);
    chk("b2b_j1", 32'(jj[1]), 32'b0101);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (dn[0]) begin seen = 1'b1; break; end
      step();
    end
    chk("b2b_second_done", 32'(seen), 32'd1);
    chk("b2b_q_second", 32'(qf[0]), 32'b0110);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
